// File: rtl/rpn_display_pkg.sv
// Shared constants for the RPN calculator display stage: active-low
// seven-segment glyphs ({g,f,e,d,c,b,a}, 0 = segment lit) and the
// display FSM state encodings.
package rpn_display_pkg;

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_ONE   = 7'b1111001;
    localparam logic [6:0] SEG_TWO   = 7'b0100100;
    localparam logic [6:0] SEG_THREE = 7'b0110000;
    localparam logic [6:0] SEG_FOUR  = 7'b0011001;
    localparam logic [6:0] SEG_FIVE  = 7'b0010010;
    localparam logic [6:0] SEG_SIX   = 7'b0000010;
    localparam logic [6:0] SEG_SEVEN = 7'b1111000;
    localparam logic [6:0] SEG_EIGHT = 7'b0000000;
    localparam logic [6:0] SEG_NINE  = 7'b0010000;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_O     = 7'b0100011;
    localparam logic [6:0] SEG_OFF   = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

endpackage

// File: rtl/rpn_display_seg7_digit.sv
// One decimal digit to active-low seven-segment pattern. Codes above 9
// and the blank request both produce a dark digit.
module seg7_digit
    import rpn_display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    // Glyph lookup
    always_comb begin
        seg = SEG_OFF;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_ZERO;
                4'd1:    seg = SEG_ONE;
                4'd2:    seg = SEG_TWO;
                4'd3:    seg = SEG_THREE;
                4'd4:    seg = SEG_FOUR;
                4'd5:    seg = SEG_FIVE;
                4'd6:    seg = SEG_SIX;
                4'd7:    seg = SEG_SEVEN;
                4'd8:    seg = SEG_EIGHT;
                4'd9:    seg = SEG_NINE;
                default: seg = SEG_OFF;
            endcase
        end
    end

endmodule

// File: rtl/rpn_display.sv
// Display stage of the RPN calculator: converts the top-of-stack byte to
// decimal with a one-bit-per-cycle double-dabble and drives registered
// seven-segment patterns on HEX0..HEX5.
//
// Display layout: HEX0 ones (always shown), HEX1 tens (blank when it and
// the hundreds are zero), HEX2 hundreds (blank when zero), HEX3 minus sign
// for negative signed values, HEX4/HEX5 dark.
// Error: HEX2=E, HEX1=r, HEX0=r; HEX3..HEX5=OFF.
//
// state   | meaning
// S_IDLE  | waiting for start; captures value/signed_mode/error
// S_LOAD  | sign split, magnitude and BCD register initialised
// S_SHIFT | WIDTH add-3/shift steps, cnt counts down to terminal count
// S_LATCH | HEX registers written, done pulsed, back to idle
//
// The HEX mapping below assumes DIGITS = 3 (HEX2..HEX0).
module rpn_display
    import rpn_display_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] value,
    input  logic             signed_mode,
    input  logic             error,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3,
    output logic [6:0]       HEX4,
    output logic [6:0]       HEX5
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    logic [1:0]       state;
    logic [WIDTH-1:0] val_q;
    logic             sgn_q;
    logic             err_q;
    logic             neg_q;
    logic [WIDTH-1:0] mag;
    logic [BW-1:0]    bcd;
    logic [BW-1:0]    bcd_adj;
    logic [CW-1:0]    cnt;
    logic [DIGITS-1:0] lead_zero;
    logic             zero_run;
    logic [6:0]       seg_w [DIGITS];

    // Double-dabble correction: nibbles of 5 or more get 3 added before the shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
    end

    // Leading-zero blanking from the top digit down; the ones digit is never blanked
    always_comb begin
        lead_zero = '0;
        zero_run  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run     = zero_run & (bcd[i*4 +: 4] == 4'd0);
            lead_zero[i] = zero_run;
        end
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            seg7_digit u_digit (
                .bcd   (bcd[g*4 +: 4]),
                .blank (lead_zero[g]),
                .seg   (seg_w[g])
            );
        end
    endgenerate

    // Conversion FSM and registered display outputs
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            val_q <= '0;
            sgn_q <= 1'b0;
            err_q <= 1'b0;
            neg_q <= 1'b0;
            mag   <= '0;
            bcd   <= '0;
            cnt   <= '0;
            HEX0  <= SEG_ZERO;
            HEX1  <= SEG_OFF;
            HEX2  <= SEG_OFF;
            HEX3  <= SEG_OFF;
            HEX4  <= SEG_OFF;
            HEX5  <= SEG_OFF;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        val_q <= value;
                        sgn_q <= signed_mode;
                        err_q <= error;
                        busy  <= 1'b1;
                        state <= error ? S_LATCH : S_LOAD;
                    end
                end
                S_LOAD: begin
                    neg_q <= sgn_q & val_q[WIDTH-1];
                    mag   <= (sgn_q & val_q[WIDTH-1]) ? (~val_q + 1'b1) : val_q;
                    bcd   <= '0;
                    cnt   <= CW'(WIDTH);
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    bcd <= {bcd_adj[BW-2:0], mag[WIDTH-1]};
                    mag <= {mag[WIDTH-2:0], 1'b0};
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1))
                        state <= S_LATCH;
                end
                S_LATCH: begin
                    if (err_q) begin
                        HEX0 <= SEG_R;
                        HEX1 <= SEG_R;
                        HEX2 <= SEG_E;
                        HEX3 <= SEG_OFF;
                    end else begin
                        HEX0 <= seg_w[0];
                        HEX1 <= seg_w[1];
                        HEX2 <= seg_w[2];
                        HEX3 <= neg_q ? SEG_MINUS : SEG_OFF;
                    end
                    HEX4  <= SEG_OFF;
                    HEX5  <= SEG_OFF;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_display.sv
// Directed bench for rpn_display: reset values, unsigned/signed/zero
// conversions, error display, busy/ignore behaviour, reset abort and
// back-to-back starts.
module tb_rpn_display;

    localparam logic [6:0] ZERO  = 7'b1000000;
    localparam logic [6:0] ONE   = 7'b1111001;
    localparam logic [6:0] TWO   = 7'b0100100;
    localparam logic [6:0] THREE = 7'b0110000;
    localparam logic [6:0] FOUR  = 7'b0011001;
    localparam logic [6:0] FIVE  = 7'b0010010;
    localparam logic [6:0] SEVEN = 7'b1111000;
    localparam logic [6:0] EIGHT = 7'b0000000;
    localparam logic [6:0] LET_E = 7'b0000110;
    localparam logic [6:0] LET_R = 7'b0101111;
    localparam logic [6:0] OFF   = 7'b1111111;
    localparam logic [6:0] MINUS = 7'b0111111;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n;
    logic [7:0] value;
    logic       signed_mode;
    logic       error;
    logic       start;
    logic       busy;
    logic       done;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int checks = 0;
    int errors = 0;

    rpn_display dut (
        .CLOCK_50    (CLOCK_50),
        .reset_n     (reset_n),
        .value       (value),
        .signed_mode (signed_mode),
        .error       (error),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .HEX0        (HEX0),
        .HEX1        (HEX1),
        .HEX2        (HEX2),
        .HEX3        (HEX3),
        .HEX4        (HEX4),
        .HEX5        (HEX5)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Pulse start from a negedge, then count posedges until done is seen.
    // edges = number of posedges after the accepting edge; 99 on timeout.
    task automatic run_conv(input logic [7:0] v, input logic sm, input logic er,
                            output int edges, output logic busy_s);
        value       = v;
        signed_mode = sm;
        error       = er;
        start       = 1'b1;
        @(negedge CLOCK_50);
        start  = 1'b0;
        busy_s = busy;
        edges  = 99;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLOCK_50);
            if (done) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; value = 8'd0; signed_mode = 1'b0; error = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        reset_n = 1'b1;
        @(negedge CLOCK_50);
        checks++;
        if ({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== {OFF, OFF, OFF, OFF, OFF, ZERO}) begin
            errors++;
            $display("FAIL reset_hex: got %h%h%h%h%h%h want %h%h%h%h%h%h",
                     HEX5, HEX4, HEX3, HEX2, HEX1, HEX0, OFF, OFF, OFF, OFF, OFF, ZERO);
        end
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: busy/done got %b%b want 00", busy, done);
        end
    endtask

    task automatic test_unsigned();
        int e; logic b;
        run_conv(8'd173, 1'b0, 1'b0, e, b);
        checks++;
        if (b !== 1'b1) begin errors++; $display("FAIL u173_busy: got %b want 1", b); end
        checks++;
        if (e != 10) begin errors++; $display("FAIL u173_latency: got %0d want 10", e); end
        checks++;
        if ({HEX3, HEX2, HEX1, HEX0} !== {OFF, ONE, SEVEN, THREE}) begin
            errors++;
            $display("FAIL u173_hex: got %h %h %h %h want %h %h %h %h",
                     HEX3, HEX2, HEX1, HEX0, OFF, ONE, SEVEN, THREE);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL u173_busy_clr: got %b want 0", busy); end
        @(negedge CLOCK_50);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL u173_done_pulse: got %b want 0", done); end
        checks++;
        if ({HEX5, HEX4} !== {OFF, OFF}) begin
            errors++; $display("FAIL u173_hex54: got %h %h want %h %h", HEX5, HEX4, OFF, OFF);
        end

        run_conv(8'hFF, 1'b0, 1'b0, e, b);
        checks++;
        if (e != 10 || {HEX3, HEX2, HEX1, HEX0} !== {OFF, TWO, FIVE, FIVE}) begin
            errors++;
            $display("FAIL u255: lat %0d hex %h %h %h %h want lat 10 hex %h %h %h %h",
                     e, HEX3, HEX2, HEX1, HEX0, OFF, TWO, FIVE, FIVE);
        end
        run_conv(8'd105, 1'b0, 1'b0, e, b);
        checks++;
        if (e != 10 || {HEX3, HEX2, HEX1, HEX0} !== {OFF, ONE, ZERO, FIVE}) begin
            errors++;
            $display("FAIL u105: lat %0d hex %h %h %h %h want lat 10 hex %h %h %h %h",
                     e, HEX3, HEX2, HEX1, HEX0, OFF, ONE, ZERO, FIVE);
        end
    endtask

    task automatic test_signed();
        int e; logic b;
        run_conv(8'hF6, 1'b1, 1'b0, e, b);
        checks++;
        if (e != 10 || {HEX3, HEX2, HEX1, HEX0} !== {MINUS, OFF, ONE, ZERO}) begin
            errors++;
            $display("FAIL s_m10: lat %0d hex %h %h %h %h want lat 10 hex %h %h %h %h",
                     e, HEX3, HEX2, HEX1, HEX0, MINUS, OFF, ONE, ZERO);
        end
        run_conv(8'h80, 1'b1, 1'b0, e, b);
        checks++;
        if (e != 10 || {HEX3, HEX2, HEX1, HEX0} !== {MINUS, ONE, TWO, EIGHT}) begin
            errors++;
            $display("FAIL s_m128: lat %0d hex %h %h %h %h want lat 10 hex %h %h %h %h",
                     e, HEX3, HEX2, HEX1, HEX0, MINUS, ONE, TWO, EIGHT);
        end
        run_conv(8'hFF, 1'b1, 1'b0, e, b);
        checks++;
        if (e != 10 || {HEX3, HEX2, HEX1, HEX0} !== {MINUS, OFF, OFF, ONE}) begin
            errors++;
            $display("FAIL s_m1: lat %0d hex %h %h %h %h want lat 10 hex %h %h %h %h",
                     e, HEX3, HEX2, HEX1, HEX0, MINUS, OFF, OFF, ONE);
        end
        run_conv(8'h7F, 1'b1, 1'b0, e, b);
        checks++;
        if (e != 10 || {HEX3, HEX2, HEX1, HEX0} !== {OFF, ONE, TWO, SEVEN}) begin
            errors++;
            $display("FAIL s_p127: lat %0d hex %h %h %h %h want lat 10 hex %h %h %h %h",
                     e, HEX3, HEX2, HEX1, HEX0, OFF, ONE, TWO, SEVEN);
        end
    endtask

    task automatic test_small();
        int e; logic b;
        run_conv(8'd0, 1'b0, 1'b0, e, b);
        checks++;
        if (e != 10 || {HEX3, HEX2, HEX1, HEX0} !== {OFF, OFF, OFF, ZERO}) begin
            errors++;
            $display("FAIL zero: lat %0d hex %h %h %h %h want lat 10 hex %h %h %h %h",
                     e, HEX3, HEX2, HEX1, HEX0, OFF, OFF, OFF, ZERO);
        end
        run_conv(8'd7, 1'b0, 1'b0, e, b);
        checks++;
        if (e != 10 || {HEX3, HEX2, HEX1, HEX0} !== {OFF, OFF, OFF, SEVEN}) begin
            errors++;
            $display("FAIL seven: lat %0d hex %h %h %h %h want lat 10 hex %h %h %h %h",
                     e, HEX3, HEX2, HEX1, HEX0, OFF, OFF, OFF, SEVEN);
        end
    endtask

    task automatic test_error();
        int e; logic b;
        run_conv(8'hF6, 1'b1, 1'b1, e, b);
        checks++;
        if (e != 1) begin errors++; $display("FAIL err_latency: got %0d want 1", e); end
        checks++;
        if ({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== {OFF, OFF, OFF, LET_E, LET_R, LET_R}) begin
            errors++;
            $display("FAIL err_hex: got %h %h %h %h %h %h want %h %h %h %h %h %h",
                     HEX5, HEX4, HEX3, HEX2, HEX1, HEX0, OFF, OFF, OFF, LET_E, LET_R, LET_R);
        end
        run_conv(8'd42, 1'b0, 1'b0, e, b);
        checks++;
        if (e != 10 || {HEX3, HEX2, HEX1, HEX0} !== {OFF, OFF, FOUR, TWO}) begin
            errors++;
            $display("FAIL err_restore: lat %0d hex %h %h %h %h want lat 10 hex %h %h %h %h",
                     e, HEX3, HEX2, HEX1, HEX0, OFF, OFF, FOUR, TWO);
        end
    endtask

    task automatic test_busy_ignore();
        int e;
        value = 8'd173; signed_mode = 1'b0; error = 1'b0; start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy: got %b want 1", busy); end
        value = 8'd9; start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        e = 99;
        for (int i = 6; i <= 20; i++) begin
            if (done) begin e = i - 1; break; end
            @(negedge CLOCK_50);
        end
        checks++;
        if (e != 10 || {HEX3, HEX2, HEX1, HEX0} !== {OFF, ONE, SEVEN, THREE}) begin
            errors++;
            $display("FAIL ign_result: lat %0d hex %h %h %h %h want lat 10 hex %h %h %h %h",
                     e, HEX3, HEX2, HEX1, HEX0, OFF, ONE, SEVEN, THREE);
        end
        // No spurious second conversion from the ignored start
        repeat (12) @(negedge CLOCK_50);
        checks++;
        if ({busy, HEX1, HEX0} !== {1'b0, SEVEN, THREE}) begin
            errors++;
            $display("FAIL ign_no_requeue: busy %b hex %h %h want 0 %h %h", busy, HEX1, HEX0, SEVEN, THREE);
        end
    endtask

    task automatic test_reset_abort();
        int e; logic b; logic seen;
        value = 8'd173; signed_mode = 1'b0; error = 1'b0; start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        reset_n = 1'b0;
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge CLOCK_50);
            if (done) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done: got done, want none"); end
        checks++;
        if ({busy, HEX3, HEX2, HEX1, HEX0} !== {1'b0, OFF, OFF, OFF, ZERO}) begin
            errors++;
            $display("FAIL abort_hex: busy %b hex %h %h %h %h want 0 %h %h %h %h",
                     busy, HEX3, HEX2, HEX1, HEX0, OFF, OFF, OFF, ZERO);
        end
        run_conv(8'd7, 1'b0, 1'b0, e, b);
        checks++;
        if (e != 10 || {HEX3, HEX2, HEX1, HEX0} !== {OFF, OFF, OFF, SEVEN}) begin
            errors++;
            $display("FAIL abort_recover: lat %0d hex %h %h %h %h want lat 10 hex %h %h %h %h",
                     e, HEX3, HEX2, HEX1, HEX0, OFF, OFF, OFF, SEVEN);
        end
    endtask

    task automatic test_back_to_back();
        int e; logic b;
        run_conv(8'd173, 1'b0, 1'b0, e, b);
        // Called again at the negedge where done is high: start must be accepted
        run_conv(8'hFF, 1'b0, 1'b0, e, b);
        checks++;
        if (b !== 1'b1 || e != 10 || {HEX2, HEX1, HEX0} !== {TWO, FIVE, FIVE}) begin
            errors++;
            $display("FAIL b2b_numeric: busy %b lat %0d hex %h %h %h want 1 10 %h %h %h",
                     b, e, HEX2, HEX1, HEX0, TWO, FIVE, FIVE);
        end
        run_conv(8'd0, 1'b0, 1'b1, e, b);
        checks++;
        if (e != 1 || {HEX2, HEX1, HEX0} !== {LET_E, LET_R, LET_R}) begin
            errors++;
            $display("FAIL b2b_error: lat %0d hex %h %h %h want 1 %h %h %h",
                     e, HEX2, HEX1, HEX0, LET_E, LET_R, LET_R);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_small();
        test_error();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
